// File: rtl/wordline_decoder_pipe_if.sv
// ============================================================================
// Module   : wordline_decoder_pipe_if
// Brief    : Request / wordline handshake bundle for wordline_decoder_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface wordline_decoder_pipe_if #(
    parameter int ADDR_W   = 7,
    parameter int NUM_ROWS = 128
);
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic                req_en;
    logic                sweep_start;
    logic                wl_valid;
    logic                wl_ready;
    logic [NUM_ROWS-1:0] wl;
    logic [ADDR_W-1:0]   wl_idx;
    logic                addr_err;
    logic                busy;
    logic                sweep_done;

    modport master (
        output req_valid, req_addr, req_en, sweep_start, wl_ready,
        input  req_ready, wl_valid, wl, wl_idx, addr_err, busy, sweep_done
    );

    modport slave (
        input  req_valid, req_addr, req_en, sweep_start, wl_ready,
        output req_ready, wl_valid, wl, wl_idx, addr_err, busy, sweep_done
    );
endinterface

`default_nettype wire

// File: rtl/wordline_decoder_pipe.sv
// ============================================================================
// Module   : wordline_decoder_pipe
// Brief    : Registered one-hot row decoder with valid/ready output stage and
//            an optional all-row sweep, compiled in by macro WLDEC_SWEEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wordline_decoder_pipe #(
    parameter int ADDR_W   = 7,
    parameter int NUM_ROWS = 128
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    wordline_decoder_pipe_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [NUM_ROWS-1:0] ONE_HOT0 = {{(NUM_ROWS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0]   LAST_ROW = ADDR_W'(NUM_ROWS - 1);
    localparam logic [ADDR_W:0]     ROWS_EXT = (ADDR_W + 1)'(NUM_ROWS);

    state_t              state_q,    state_d;
    logic [ADDR_W-1:0]   row_q,      row_d;
    logic [NUM_ROWS-1:0] wl_q,       wl_d;
    logic [ADDR_W-1:0]   wl_idx_q,   wl_idx_d;
    logic                addr_err_q, addr_err_d;
    logic                wl_valid_q, wl_valid_d;
    logic                sweep_done_q, sweep_done_d;

    logic              start_sweep;
    logic              out_free;
    logic              xfer;
    logic              accept;
    logic              addr_in_range;
    logic [ADDR_W-1:0] row_next;

`ifdef WLDEC_SWEEP_EN
    assign start_sweep = bus.sweep_start;
`else
    logic sweep_start_unused;
    assign sweep_start_unused = bus.sweep_start;
    assign start_sweep        = 1'b0;
`endif

    assign out_free      = !wl_valid_q || bus.wl_ready;
    assign xfer          = wl_valid_q && bus.wl_ready;
    assign bus.req_ready = (state_q == IDLE) && !start_sweep && out_free;
    assign accept        = bus.req_valid && bus.req_ready;
    assign addr_in_range = ({1'b0, bus.req_addr} < ROWS_EXT);
    assign row_next      = row_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        wl_d         = wl_q;
        wl_idx_d     = wl_idx_q;
        addr_err_d   = addr_err_q;
        wl_valid_d   = wl_valid_q;
        sweep_done_d = 1'b0;

        if (xfer) begin
            wl_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                // A sweep request wins over a pending decode request.
                if (start_sweep && out_free) begin
                    state_d    = SWEEP;
                    row_d      = '0;
                    wl_d       = ONE_HOT0;
                    wl_idx_d   = '0;
                    addr_err_d = 1'b0;
                    wl_valid_d = 1'b1;
                end else if (accept) begin
                    wl_d       = (bus.req_en && addr_in_range) ? (ONE_HOT0 << bus.req_addr) : '0;
                    wl_idx_d   = bus.req_addr;
                    addr_err_d = bus.req_en && !addr_in_range;
                    wl_valid_d = 1'b1;
                end
            end
            SWEEP: begin
                if (xfer) begin
                    if (row_q == LAST_ROW) begin
                        state_d      = IDLE;
                        row_d        = '0;
                        sweep_done_d = 1'b1;
                    end else begin
                        row_d      = row_next;
                        wl_d       = ONE_HOT0 << row_next;
                        wl_idx_d   = row_next;
                        addr_err_d = 1'b0;
                        wl_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            wl_q         <= '0;
            wl_idx_q     <= '0;
            addr_err_q   <= 1'b0;
            wl_valid_q   <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            wl_q         <= wl_d;
            wl_idx_q     <= wl_idx_d;
            addr_err_q   <= addr_err_d;
            wl_valid_q   <= wl_valid_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign bus.wl         = wl_q;
    assign bus.wl_idx     = wl_idx_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.wl_valid   = wl_valid_q;
    assign bus.busy       = (state_q == SWEEP);
    assign bus.sweep_done = sweep_done_q;

endmodule

`default_nettype wire

// File: tb/tb_wordline_decoder_pipe.sv
// ============================================================================
// Module   : tb_wordline_decoder_pipe
// Brief    : Scoreboard bench: a 100-row decoder for requests and a 4-row
//            decoder for sweep behaviour (sweep checks need WLDEC_SWEEP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wordline_decoder_pipe;

    typedef struct packed {
        logic [127:0] wl;
        logic [6:0]   idx;
        logic         err;
        logic         busy;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;
    int b_pops   = 0;
    int sd_count = 0;
    int last_b_idx = -1;

    exp_t qa[$];
    exp_t qb[$];

    wordline_decoder_pipe_if #(.ADDR_W(7), .NUM_ROWS(100)) ia ();
    wordline_decoder_pipe_if #(.ADDR_W(3), .NUM_ROWS(4))   ib ();

    wordline_decoder_pipe #(.ADDR_W(7), .NUM_ROWS(100)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    wordline_decoder_pipe #(.ADDR_W(3), .NUM_ROWS(4))   dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_a(input logic [6:0] addr, input logic en);
        exp_t e;
        logic in_rng;
        in_rng = (int'(addr) < 100);
        e.wl   = (en && in_rng) ? (128'd1 << addr) : 128'd0;
        e.idx  = addr;
        e.err  = en && !in_rng;
        e.busy = 1'b0;
        return e;
    endfunction

    function automatic exp_t mk_b(input logic [2:0] addr, input logic en, input logic busy);
        exp_t e;
        logic in_rng;
        in_rng = (int'(addr) < 4);
        e.wl   = (en && in_rng) ? (128'd1 << addr) : 128'd0;
        e.idx  = {4'd0, addr};
        e.err  = en && !in_rng;
        e.busy = busy;
        return e;
    endfunction

    // Output monitors: every transfer pops and compares the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ia.wl_valid && ia.wl_ready) begin
            if (qa.size() == 0) begin
                check_eq("a_unexpected_out", ia.wl_valid, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check_eq("a_wl",   ia.wl,       e.wl);
                check_eq("a_idx",  ia.wl_idx,   e.idx);
                check_eq("a_err",  ia.addr_err, e.err);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ib.wl_valid && ib.wl_ready) begin
            if (qb.size() == 0) begin
                check_eq("b_unexpected_out", ib.wl_valid, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check_eq("b_wl",   ib.wl,       e.wl);
                check_eq("b_idx",  ib.wl_idx,   e.idx);
                check_eq("b_err",  ib.addr_err, e.err);
                check_eq("b_busy", ib.busy,     e.busy);
                last_b_idx = int'(ib.wl_idx);
                b_pops++;
            end
        end
        if (rst_n && ib.sweep_done) begin
            sd_count++;
            check_eq("sd_after_last_row", last_b_idx, 3);
        end
    end

    task automatic send_a(input logic [6:0] addr, input logic en, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        ia.req_valid = 1'b1;
        ia.req_addr  = addr;
        ia.req_en    = en;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ia.req_ready) begin
                qa.push_back(mk_a(addr, en));
                ok = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        ia.req_valid = 1'b0;
        check_eq("a_accept", ok, 1);
    endtask

    task automatic send_b(input logic [2:0] addr, input logic en, output int waits);
        bit ok;
        ok    = 1'b0;
        waits = 0;
        ib.req_valid = 1'b1;
        ib.req_addr  = addr;
        ib.req_en    = en;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (ib.req_ready) begin
                qb.push_back(mk_b(addr, en, 1'b0));
                ok = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        ib.req_valid = 1'b0;
        check_eq("b_accept", ok, 1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (qa.size() + qb.size()) != 0; i++) begin
            @(posedge clk); #1;
        end
        check_eq("drain", qa.size() + qb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0;
        ia.req_valid = 1'b0; ia.req_addr = '0; ia.req_en = 1'b0; ia.sweep_start = 1'b0; ia.wl_ready = 1'b1;
        ib.req_valid = 1'b0; ib.req_addr = '0; ib.req_en = 1'b0; ib.sweep_start = 1'b0; ib.wl_ready = 1'b1;

        @(posedge clk); #1;
        check_eq("rst_a_valid", ia.wl_valid, 0);
        check_eq("rst_a_wl",    ia.wl,       0);
        check_eq("rst_a_idx",   ia.wl_idx,   0);
        check_eq("rst_a_err",   ia.addr_err, 0);
        check_eq("rst_b_busy",  ib.busy,     0);
        check_eq("rst_b_done",  ib.sweep_done, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        send_a(7'd5, 1'b1, w);
        check_eq("lat1_valid", ia.wl_valid, 1);
        check_eq("lat1_wl",    ia.wl,       128'd1 << 5);
        send_a(7'd120, 1'b1, w);
        send_a(7'd3,   1'b0, w);
        @(posedge clk); #1;
        check_eq("valid_clear", ia.wl_valid, 0);
        send_a(7'd99,  1'b1, w);
        send_a(7'd100, 1'b1, w);
        send_a(7'd0,   1'b1, w);

        for (int i = 0; i < 8; i++) begin
            send_a(7'($urandom_range(0, 127)), (i % 5) != 0, w);
            check_eq("b2b_wait", w, 0);
        end
        repeat (2) @(posedge clk); #1;

        // Output stall: row 9 must hold while the next request waits.
        ia.wl_ready = 1'b0;
        send_a(7'd9, 1'b1, w);
        ia.req_valid = 1'b1; ia.req_addr = 7'd10; ia.req_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_valid", ia.wl_valid,  1);
            check_eq("stall_wl",    ia.wl,        128'd1 << 9);
            check_eq("stall_idx",   ia.wl_idx,    9);
            check_eq("stall_ready", ia.req_ready, 0);
            @(posedge clk); #1;
        end
        ia.wl_ready = 1'b1;
        @(negedge clk);
        check_eq("release_ready", ia.req_ready, 1);
        if (ia.req_ready) qa.push_back(mk_a(7'd10, 1'b1));
        @(posedge clk); #1;
        ia.req_valid = 1'b0;
        wait_drain();

`ifdef WLDEC_SWEEP_EN
        begin
            int acc_iter;
            int sd_base;
            acc_iter = -1;
            ib.sweep_start = 1'b1;
            ib.req_valid = 1'b1; ib.req_addr = 3'd1; ib.req_en = 1'b1;
            for (int r = 0; r < 4; r++) qb.push_back(mk_b(3'(r), 1'b1, 1'b1));
            @(negedge clk);
            check_eq("sweep_prio_ready", ib.req_ready, 0);
            @(posedge clk); #1;
            ib.sweep_start = 1'b0;
            for (int i = 0; i < 30 && acc_iter < 0; i++) begin
                ib.wl_ready = (i != 1 && i != 2);
                @(negedge clk);
                if (ib.req_ready) begin
                    qb.push_back(mk_b(3'd1, 1'b1, 1'b0));
                    acc_iter = i;
                end else begin
                    check_eq("busy_while_blocked", ib.busy, 1);
                end
                @(posedge clk); #1;
            end
            ib.req_valid = 1'b0;
            ib.wl_ready  = 1'b1;
            check_eq("req_wait_sweep", acc_iter, 6);
            wait_drain();
            repeat (2) @(posedge clk); #1;
            check_eq("sd_count_1", sd_count, 1);
            check_eq("idle_busy", ib.busy, 0);

            // Reset after row 2 has been taken.
            for (int r = 0; r < 3; r++) qb.push_back(mk_b(3'(r), 1'b1, 1'b1));
            sd_base = b_pops;
            ib.sweep_start = 1'b1;
            @(posedge clk); #1;
            ib.sweep_start = 1'b0;
            for (int i = 0; i < 20 && b_pops != sd_base + 3; i++) begin
                @(posedge clk); #1;
            end
            check_eq("pre_rst_rows", b_pops - sd_base, 3);
            ib.wl_ready = 1'b0;
            sd_base = sd_count;
            #2 rst_n = 1'b0;
            #1;
            check_eq("arst_valid", ib.wl_valid,   0);
            check_eq("arst_wl",    ib.wl,         0);
            check_eq("arst_idx",   ib.wl_idx,     0);
            check_eq("arst_err",   ib.addr_err,   0);
            check_eq("arst_busy",  ib.busy,       0);
            check_eq("arst_done",  ib.sweep_done, 0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            ib.wl_ready = 1'b1;
            check_eq("no_sd_on_abort", sd_count, sd_base);

            for (int r = 0; r < 4; r++) qb.push_back(mk_b(3'(r), 1'b1, 1'b1));
            ib.sweep_start = 1'b1;
            @(posedge clk); #1;
            ib.sweep_start = 1'b0;
            wait_drain();
            repeat (2) @(posedge clk); #1;
            check_eq("sd_after_restart", sd_count, sd_base + 1);
        end
`else
        ib.sweep_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("nosweep_busy",  ib.busy,      0);
            check_eq("nosweep_ready", ib.req_ready, 1);
            check_eq("nosweep_valid", ib.wl_valid,  0);
            @(posedge clk); #1;
        end
        send_b(3'd2, 1'b1, w);
        check_eq("nosweep_req_wait", w, 0);
        send_b(3'd5, 1'b1, w);
        send_b(3'd3, 1'b1, w);
        ib.sweep_start = 1'b0;
        wait_drain();
        check_eq("nosweep_done", sd_count, 0);
`endif

        wait_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
